// File: rtl/cmsa_pe_stream_pkg.sv
// Shared definitions for the cmsa_pe_stream processing element.
// Optional feature macro: CMSA_PE_SATURATE_EN (saturating accumulate, sticky sat_flag).
package cmsa_pe_stream_pkg;

   // Control FSM encoding; the numeric values are visible on dbg_state.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD_W  = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_DONE    = 2'd3
   } pe_state_e;

   // Width of a counter that must hold values 0..max_count inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/cmsa_pe_stream_mac.sv
// pe_mac_unit: combinational signed multiply followed by the accumulate add.
// With CMSA_PE_SATURATE_EN defined the add clamps to the signed accumulator
// range and raises sat_o; otherwise it wraps in two's complement and sat_o is 0.
module pe_mac_unit
   import cmsa_pe_stream_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ACCUM_WIDTH = 32
) (
   input  logic signed [DATA_WIDTH-1:0]  weight_i,
   input  logic signed [DATA_WIDTH-1:0]  act_i,
   input  logic signed [ACCUM_WIDTH-1:0] addend_i,
   output logic signed [ACCUM_WIDTH-1:0] sum_o,
   output logic                          sat_o
);

   logic signed [2*DATA_WIDTH-1:0] product;
   logic signed [ACCUM_WIDTH-1:0]  product_ext;

   // Full-precision product, then sign-extended into the accumulator width.
   assign product     = (2*DATA_WIDTH)'(weight_i) * (2*DATA_WIDTH)'(act_i);
   assign product_ext = ACCUM_WIDTH'(product);

`ifdef CMSA_PE_SATURATE_EN
   localparam logic [ACCUM_WIDTH-1:0] SUM_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
   localparam logic [ACCUM_WIDTH-1:0] SUM_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

   logic signed [ACCUM_WIDTH:0] wide_sum;
   logic                        overflow;

   // One guard bit: overflow when the guard and the sign bit disagree.
   assign wide_sum = (ACCUM_WIDTH+1)'(addend_i) + (ACCUM_WIDTH+1)'(product_ext);
   assign overflow = wide_sum[ACCUM_WIDTH] ^ wide_sum[ACCUM_WIDTH-1];

   // Clamp towards the true sign of the result on overflow.
   always_comb begin
      sum_o = wide_sum[ACCUM_WIDTH-1:0];
      sat_o = 1'b0;
      if (overflow) begin
         sat_o = 1'b1;
         sum_o = wide_sum[ACCUM_WIDTH] ? SUM_MIN : SUM_MAX;
      end
   end
`else
   // Plain two's-complement wrap.
   assign sum_o = addend_i + product_ext;
   assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/cmsa_pe_stream.sv
// cmsa_pe_stream: weight-stationary systolic-array cell with embedded control FSM.
// Weight arrives on a daisy chain during LOAD_W, activations stream left->right
// through a free-running pipeline, and signed products are accumulated over
// cfg_num_channels beats into one psum_out pulse per output pixel.
// Optional feature macro: CMSA_PE_SATURATE_EN (see pe_mac_unit).
//
// Stream semantics: every stream here (w_*, act_*, psum_out) is valid-only with
// no backpressure; a beat is transferred on each rising edge where its valid is
// high, and data is ignored whenever valid is low.
module cmsa_pe_stream
   import cmsa_pe_stream_pkg::*;
#(
   parameter int  DATA_WIDTH   = 16,
   parameter int  ACCUM_WIDTH  = 32,
   parameter int  ACT_STAGES   = 2,
   parameter int  MAX_CHANNELS = 256,
   parameter int  MAX_OUTPUTS  = 256,
   localparam int CW = cnt_width(MAX_CHANNELS),
   localparam int OW = cnt_width(MAX_OUTPUTS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   cfg_skip_wload,
   input  logic                   cfg_use_psum_in,
   input  logic [CW-1:0]          cfg_num_channels,
   input  logic [OW-1:0]          cfg_num_outputs,
   input  logic [DATA_WIDTH-1:0]  w_in,
   input  logic                   w_in_valid,
   input  logic                   w_load_last,
   output logic [DATA_WIDTH-1:0]  w_out,
   output logic                   w_out_valid,
   input  logic [DATA_WIDTH-1:0]  act_in,
   input  logic                   act_in_valid,
   output logic [DATA_WIDTH-1:0]  act_out,
   output logic                   act_out_valid,
   input  logic [ACCUM_WIDTH-1:0] psum_in,
   output logic [ACCUM_WIDTH-1:0] psum_out,
   output logic                   psum_out_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   sat_flag,
   output logic [1:0]             dbg_state
);

   // ---------------------------------------------------------------------------
   // Activation pipeline (independent of the FSM)
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] act_pipe_q [ACT_STAGES];
   logic [ACT_STAGES-1:0] act_vld_q;

   // Free-running shift of data and valid together; runs in every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ACT_STAGES; i++) begin
            act_pipe_q[i] <= '0;
         end
         act_vld_q <= '0;
      end else begin
         act_pipe_q[0] <= act_in;
         act_vld_q[0]  <= act_in_valid;
         for (int i = 1; i < ACT_STAGES; i++) begin
            act_pipe_q[i] <= act_pipe_q[i-1];
            act_vld_q[i]  <= act_vld_q[i-1];
         end
      end
   end

   assign act_out       = act_pipe_q[ACT_STAGES-1];
   assign act_out_valid = act_vld_q[ACT_STAGES-1];

   // ---------------------------------------------------------------------------
   // Control and datapath state
   // ---------------------------------------------------------------------------
   pe_state_e                      state_q, state_d;
   logic signed [DATA_WIDTH-1:0]   weight_q, weight_d;
   logic [DATA_WIDTH-1:0]          w_out_q, w_out_d;
   logic                           w_out_valid_q, w_out_valid_d;
   logic signed [ACCUM_WIDTH-1:0]  acc_q, acc_d;
   logic [ACCUM_WIDTH-1:0]         psum_out_q, psum_out_d;
   logic                           psum_out_valid_q, psum_out_valid_d;
   logic [CW-1:0]                  ch_cnt_q, ch_cnt_d;
   logic [OW-1:0]                  out_cnt_q, out_cnt_d;
   logic                           sat_q, sat_d;

   // Configuration shadows, captured on the accepting start edge.
   logic                           use_psum_q, use_psum_d;
   logic [CW-1:0]                  num_ch_q, num_ch_d;
   logic [OW-1:0]                  num_out_q, num_out_d;

   // MAC interface.
   logic                           mac_fire;
   logic signed [ACCUM_WIDTH-1:0]  mac_addend;
   logic signed [ACCUM_WIDTH-1:0]  mac_sum;
   logic                           mac_sat;
   logic                           last_channel;
   logic [OW-1:0]                  out_cnt_inc;

   assign mac_fire     = (state_q == ST_COMPUTE) && act_vld_q[ACT_STAGES-1];
   assign last_channel = (ch_cnt_q == (num_ch_q - CW'(1)));
   assign out_cnt_inc  = out_cnt_q + OW'(1);

   // First channel beat starts from psum_in (or zero); later beats from the accumulator.
   assign mac_addend = (ch_cnt_q == '0) ? (use_psum_q ? psum_in : '0) : acc_q;

   pe_mac_unit #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACCUM_WIDTH (ACCUM_WIDTH)
   ) u_mac (
      .weight_i (weight_q),
      .act_i    (act_pipe_q[ACT_STAGES-1]),
      .addend_i (mac_addend),
      .sum_o    (mac_sum),
      .sat_o    (mac_sat)
   );

   // Next-state and datapath updates; abort overrides every other transition.
   always_comb begin
      state_d          = state_q;
      weight_d         = weight_q;
      w_out_d          = w_out_q;
      w_out_valid_d    = 1'b0;
      acc_d            = acc_q;
      psum_out_d       = psum_out_q;
      psum_out_valid_d = 1'b0;
      ch_cnt_d         = ch_cnt_q;
      out_cnt_d        = out_cnt_q;
      sat_d            = sat_q;
      use_psum_d       = use_psum_q;
      num_ch_d         = num_ch_q;
      num_out_d        = num_out_q;

      if (abort) begin
         // Partial work is discarded; the held weight survives.
         state_d   = ST_IDLE;
         acc_d     = '0;
         ch_cnt_d  = '0;
         out_cnt_d = '0;
         sat_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  use_psum_d = cfg_use_psum_in;
                  // A zero count means a single channel / single output.
                  num_ch_d   = (cfg_num_channels == '0) ? CW'(1) : cfg_num_channels;
                  num_out_d  = (cfg_num_outputs == '0)  ? OW'(1) : cfg_num_outputs;
                  acc_d      = '0;
                  ch_cnt_d   = '0;
                  out_cnt_d  = '0;
                  sat_d      = 1'b0;
                  state_d    = cfg_skip_wload ? ST_COMPUTE : ST_LOAD_W;
               end
            end

            ST_LOAD_W: begin
               // Each accepted beat pushes the previous weight down the chain.
               if (w_in_valid) begin
                  w_out_d       = weight_q;
                  weight_d      = w_in;
                  w_out_valid_d = 1'b1;
                  if (w_load_last) begin
                     state_d = ST_COMPUTE;
                  end
               end
            end

            ST_COMPUTE: begin
               if (mac_fire) begin
                  if (mac_sat) begin
                     sat_d = 1'b1;
                  end
                  if (last_channel) begin
                     psum_out_d       = mac_sum;
                     psum_out_valid_d = 1'b1;
                     acc_d            = '0;
                     ch_cnt_d         = '0;
                     out_cnt_d        = out_cnt_inc;
                     if (out_cnt_inc == num_out_q) begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     acc_d    = mac_sum;
                     ch_cnt_d = ch_cnt_q + CW'(1);
                  end
               end
            end

            ST_DONE: begin
               state_d = ST_IDLE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State register for the FSM and all datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         weight_q         <= '0;
         w_out_q          <= '0;
         w_out_valid_q    <= 1'b0;
         acc_q            <= '0;
         psum_out_q       <= '0;
         psum_out_valid_q <= 1'b0;
         ch_cnt_q         <= '0;
         out_cnt_q        <= '0;
         sat_q            <= 1'b0;
         use_psum_q       <= 1'b0;
         num_ch_q         <= '0;
         num_out_q        <= '0;
      end else begin
         state_q          <= state_d;
         weight_q         <= weight_d;
         w_out_q          <= w_out_d;
         w_out_valid_q    <= w_out_valid_d;
         acc_q            <= acc_d;
         psum_out_q       <= psum_out_d;
         psum_out_valid_q <= psum_out_valid_d;
         ch_cnt_q         <= ch_cnt_d;
         out_cnt_q        <= out_cnt_d;
         sat_q            <= sat_d;
         use_psum_q       <= use_psum_d;
         num_ch_q         <= num_ch_d;
         num_out_q        <= num_out_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign w_out          = w_out_q;
   assign w_out_valid    = w_out_valid_q;
   assign psum_out       = psum_out_q;
   assign psum_out_valid = psum_out_valid_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign sat_flag       = sat_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_cmsa_pe_stream.sv
// Directed testbench for cmsa_pe_stream (DW=16, AW=32, ACT_STAGES=2).
// Build with CMSA_PE_SATURATE_EN defined to check the saturating variant.
module tb_cmsa_pe_stream;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int CW = 9;
   localparam int OW = 9;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start, abort, cfg_skip_wload, cfg_use_psum_in;
   logic [CW-1:0] cfg_num_channels;
   logic [OW-1:0] cfg_num_outputs;
   logic [DW-1:0] w_in, w_out, act_in, act_out;
   logic          w_in_valid, w_load_last, w_out_valid, act_in_valid, act_out_valid;
   logic [AW-1:0] psum_in, psum_out;
   logic          psum_out_valid, busy, done, sat_flag;
   logic [1:0]    dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   cmsa_pe_stream #(
      .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .ACT_STAGES(2),
      .MAX_CHANNELS(256), .MAX_OUTPUTS(256)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_skip_wload(cfg_skip_wload), .cfg_use_psum_in(cfg_use_psum_in),
      .cfg_num_channels(cfg_num_channels), .cfg_num_outputs(cfg_num_outputs),
      .w_in(w_in), .w_in_valid(w_in_valid), .w_load_last(w_load_last),
      .w_out(w_out), .w_out_valid(w_out_valid),
      .act_in(act_in), .act_in_valid(act_in_valid),
      .act_out(act_out), .act_out_valid(act_out_valid),
      .psum_in(psum_in), .psum_out(psum_out), .psum_out_valid(psum_out_valid),
      .busy(busy), .done(done), .sat_flag(sat_flag), .dbg_state(dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; abort = 0; cfg_skip_wload = 0; cfg_use_psum_in = 0;
      cfg_num_channels = '0; cfg_num_outputs = '0;
      w_in = '0; w_in_valid = 0; w_load_last = 0;
      act_in = '0; act_in_valid = 0; psum_in = '0;
   endtask

   task automatic start_run(input logic skip, input logic use_psum, input int nch, input int nout);
      cfg_skip_wload   = skip;
      cfg_use_psum_in  = use_psum;
      cfg_num_channels = CW'(nch);
      cfg_num_outputs  = OW'(nout);
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic load_single_weight(input logic [DW-1:0] w);
      w_in = w; w_in_valid = 1; w_load_last = 1;
      tick();
      w_in_valid = 0; w_load_last = 0;
   endtask

   task automatic do_abort();
      abort = 1;
      tick();
      abort = 0;
   endtask

   // Drives n beats then idles until total cycles; records psum pulses and done pulses.
   // pulse_at is the loop index of the tick after which the last pulse was seen.
   task automatic run_acts(input logic [DW-1:0] d [8], input logic v [8], input int n,
                           input int total, output int pulses, output logic [AW-1:0] sum,
                           output int pulse_at, output int dones);
      pulses = 0; sum = '0; pulse_at = -1; dones = 0;
      for (int i = 0; i < total; i++) begin
         if (i < n) begin
            act_in = d[i]; act_in_valid = v[i];
         end else begin
            act_in = '0; act_in_valid = 0;
         end
         tick();
         if (psum_out_valid) begin
            pulses++; sum = psum_out; pulse_at = i;
         end
         if (done) dones++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_tests++;
      if ({psum_out, psum_out_valid, w_out, w_out_valid, act_out, act_out_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got psum=%h/%b w=%h/%b act=%h/%b expected all 0",
                  psum_out, psum_out_valid, w_out, w_out_valid, act_out, act_out_valid);
      end
      n_tests++;
      if ({busy, done, sat_flag, dbg_state} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy=%b done=%b sat=%b state=%0d expected 0", busy, done, sat_flag, dbg_state);
      end
   endtask

   task automatic test_weight_chain();
      logic [DW-1:0] wv [3];
      logic [DW-1:0] ev [3];
      wv = '{16'd5, 16'hFFFE, 16'd7};
      ev = '{16'd0, 16'd5, 16'hFFFE};
      start_run(0, 1, 4, 1);
      n_tests++;
      if (dbg_state !== 2'd1) begin
         n_fail++; $display("FAIL t2_enter_load: got state %0d expected 1", dbg_state);
      end
      for (int i = 0; i < 3; i++) begin
         w_in = wv[i]; w_in_valid = 1; w_load_last = (i == 2);
         tick();
         n_tests++;
         if (w_out !== ev[i] || w_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL t2_w_out[%0d]: got %h/%b expected %h/1", i, w_out, w_out_valid, ev[i]);
         end
      end
      w_in_valid = 0; w_load_last = 0;
      n_tests++;
      if (dbg_state !== 2'd2) begin
         n_fail++; $display("FAIL t2_to_compute: got state %0d expected 2", dbg_state);
      end
      tick();
      n_tests++;
      if (w_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL t2_w_valid_drop: got %b expected 0", w_out_valid);
      end
      do_abort();
      n_tests++;
      if (dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL t2_abort_idle: got state %0d expected 0", dbg_state);
      end
   endtask

   task automatic test_mac();
      logic [DW-1:0] d [8];
      logic v [8];
      int pulses, pulse_at, dones;
      logic [AW-1:0] sum;
      d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
      v = '{1, 1, 1, 1, 0, 0, 0, 0};
      psum_in = 32'd100;
      start_run(0, 1, 4, 1);
      // Later cfg changes must not disturb the run.
      cfg_num_channels = 9'd1; cfg_use_psum_in = 0;
      load_single_weight(16'd3);
      n_tests++;
      if (w_out !== 16'd7) begin
         n_fail++; $display("FAIL t3_prev_weight: got w_out %0d expected 7", w_out);
      end
      run_acts(d, v, 4, 8, pulses, sum, pulse_at, dones);
      n_tests++;
      if (pulses !== 1 || sum !== 32'd130) begin
         n_fail++; $display("FAIL t3_psum: got %0d pulses value %0d expected 1 pulse value 130", pulses, sum);
      end
      n_tests++;
      if (pulse_at !== 5 || dones !== 1) begin
         n_fail++; $display("FAIL t3_latency: got pulse at %0d dones %0d expected 5 and 1", pulse_at, dones);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL t3_idle: got busy %b expected 0", busy);
      end
   endtask

   task automatic test_gaps_multi();
      logic [DW-1:0] d [11];
      logic v [11];
      logic [DW-1:0] prev_d;
      logic prev_v;
      logic [AW-1:0] exp_q [$];
      int exp_at [$];
      int pulses;
      d = '{16'd2, 16'd99, 16'd5, 16'd98, 16'hFFFF, 16'd97, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
      v = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
      exp_q = '{32'd21, 32'd9};
      exp_at = '{4, 8};
      psum_in = 32'd12345;
      start_run(1, 0, 2, 2);
      n_tests++;
      if (dbg_state !== 2'd2) begin
         n_fail++; $display("FAIL t4_skip_load: got state %0d expected 2", dbg_state);
      end
      prev_d = '0; prev_v = 0;
      pulses = 0;
      for (int i = 0; i < 11; i++) begin
         act_in = d[i]; act_in_valid = v[i];
         tick();
         n_tests++;
         if (act_out !== prev_d || act_out_valid !== prev_v) begin
            n_fail++; $display("FAIL t4_act_out[%0d]: got %h/%b expected %h/%b", i, act_out, act_out_valid, prev_d, prev_v);
         end
         if (psum_out_valid) begin
            pulses++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL t4_extra_pulse: got value %0d at %0d expected none", psum_out, i);
            end else begin
               if (psum_out !== exp_q[0] || i !== exp_at[0]) begin
                  n_fail++; $display("FAIL t4_psum: got %0d at %0d expected %0d at %0d", psum_out, i, exp_q[0], exp_at[0]);
               end
               void'(exp_q.pop_front());
               void'(exp_at.pop_front());
            end
         end
         prev_d = d[i]; prev_v = v[i];
      end
      n_tests++;
      if (pulses !== 2 || busy !== 1'b0) begin
         n_fail++; $display("FAIL t4_count: got %0d pulses busy %b expected 2 pulses busy 0", pulses, busy);
      end
   endtask

   task automatic test_abort_start();
      logic [DW-1:0] d [8];
      logic v [8];
      int pulses, pulse_at, dones;
      logic [AW-1:0] sum;
      d = '{16'd2, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      v = '{1, 1, 0, 0, 0, 0, 0, 0};
      start_run(1, 0, 4, 1);
      run_acts(d, v, 2, 4, pulses, sum, pulse_at, dones);
      do_abort();
      n_tests++;
      if (dbg_state !== 2'd0 || busy !== 1'b0 || pulses !== 0) begin
         n_fail++; $display("FAIL t5_abort: got state %0d busy %b pulses %0d expected 0 0 0", dbg_state, busy, pulses);
      end
      // Restart without reloading: weight 3 must still be held.
      d = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      start_run(1, 0, 2, 1);
      n_tests++;
      if (dbg_state !== 2'd2) begin
         n_fail++; $display("FAIL t5_no_load: got state %0d expected 2", dbg_state);
      end
      run_acts(d, v, 2, 6, pulses, sum, pulse_at, dones);
      n_tests++;
      if (pulses !== 1 || sum !== 32'd6 || dones !== 1) begin
         n_fail++; $display("FAIL t5_rerun: got %0d pulses value %0d dones %0d expected 1 6 1", pulses, sum, dones);
      end
      // Zero counts behave as one channel, one output.
      d = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      v = '{1, 0, 0, 0, 0, 0, 0, 0};
      start_run(1, 0, 0, 0);
      run_acts(d, v, 1, 5, pulses, sum, pulse_at, dones);
      n_tests++;
      if (pulses !== 1 || sum !== 32'd15 || pulse_at !== 2 || busy !== 1'b0) begin
         n_fail++; $display("FAIL t5_zero_cfg: got %0d pulses value %0d at %0d busy %b expected 1 15 2 0", pulses, sum, pulse_at, busy);
      end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] d [8];
      logic v [8];
      int pulses, pulse_at, dones;
      logic [AW-1:0] sum;
      logic [AW-1:0] exp_sum;
      logic exp_sat;
`ifdef CMSA_PE_SATURATE_EN
      exp_sum = 32'h7FFF_FFFF; exp_sat = 1'b1;
`else
      exp_sum = 32'h3FFC_0003; exp_sat = 1'b0;
`endif
      d = '{16'd32767, 16'd32767, 16'd32767, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      v = '{1, 1, 1, 0, 0, 0, 0, 0};
      psum_in = 32'h7FFF_0000;
      start_run(0, 1, 3, 1);
      load_single_weight(16'd32767);
      run_acts(d, v, 3, 7, pulses, sum, pulse_at, dones);
      n_tests++;
      if (pulses !== 1 || sum !== exp_sum) begin
         n_fail++; $display("FAIL t6_sum: got %0d pulses value %h expected 1 value %h", pulses, sum, exp_sum);
      end
      n_tests++;
      if (sat_flag !== exp_sat) begin
         n_fail++; $display("FAIL t6_sat_sticky: got %b expected %b", sat_flag, exp_sat);
      end
      start_run(1, 0, 1, 1);
      n_tests++;
      if (sat_flag !== 1'b0) begin
         n_fail++; $display("FAIL t6_sat_clear: got %b expected 0", sat_flag);
      end
      do_abort();
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] d [8];
      logic v [8];
      bit seen;
      d = '{16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      v = '{1, 0, 0, 0, 0, 0, 0, 0};
      start_run(1, 0, 1, 2);
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         act_in = d[i]; act_in_valid = v[i];
         tick();
         if (psum_out_valid) seen = 1;
      end
      act_in = '0; act_in_valid = 0;
      n_tests++;
      if (!seen || psum_out !== 32'd131068 || dbg_state !== 2'd2) begin
         n_fail++; $display("FAIL t1_setup: got seen=%0d psum=%0d state=%0d expected 1 131068 2", seen, psum_out, dbg_state);
      end
      // Assert reset between clock edges; outputs must clear without an edge.
      #2 reset = 0;
      #1;
      n_tests++;
      if ({psum_out, psum_out_valid, w_out, w_out_valid, act_out, act_out_valid} !== '0) begin
         n_fail++; $display("FAIL t1_async_data: got psum=%h/%b w=%h/%b act=%h/%b expected all 0",
                            psum_out, psum_out_valid, w_out, w_out_valid, act_out, act_out_valid);
      end
      n_tests++;
      if ({busy, done, sat_flag, dbg_state} !== 5'b0) begin
         n_fail++; $display("FAIL t1_async_ctrl: got busy=%b done=%b sat=%b state=%0d expected 0", busy, done, sat_flag, dbg_state);
      end
      tick();
      reset = 1;
      tick();
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      clear_inputs();
      repeat (3) tick();
      test_reset();
      reset = 1;
      tick();
      test_weight_chain();
      test_mac();
      test_gaps_multi();
      test_abort_start();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
